// File: rtl/seg7_pkg.sv
// Shared code constants and glyph decode for the seven-segment scan driver.
// Segment vectors are {a,b,c,d,e,f,g} with bit6 = a.
package seg7_pkg;

    localparam logic [3:0] CODE_L     = 4'hA;
    localparam logic [3:0] CODE_C     = 4'hB;
    localparam logic [3:0] CODE_BLANK = 4'hC;
    localparam logic [3:0] CODE_P     = 4'hD;
    localparam logic [3:0] CODE_N     = 4'hE;
    localparam logic [3:0] CODE_A     = 4'hF;

    localparam logic [6:0] SEG_BLANK  = 7'b0000000;

    function automatic logic [6:0] glyph(input logic [3:0] code);
        logic [6:0] g;
        case (code)
            4'h0:       g = 7'b1111110;
            4'h1:       g = 7'b0110000;
            4'h2:       g = 7'b1101101;
            4'h3:       g = 7'b1111001;
            4'h4:       g = 7'b0110011;
            4'h5:       g = 7'b1011011;
            4'h6:       g = 7'b1011111;
            4'h7:       g = 7'b1110000;
            4'h8:       g = 7'b1111111;
            4'h9:       g = 7'b1111011;
            CODE_L:     g = 7'b0001110;
            CODE_C:     g = 7'b1001110;
            CODE_BLANK: g = SEG_BLANK;
            CODE_P:     g = 7'b1100111;
            CODE_N:     g = 7'b1110110;
            CODE_A:     g = 7'b1110111;
            default:    g = SEG_BLANK;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg7_scan_display_glyph.sv
// Combinational 4-bit code to 7-segment glyph decoder.
module seg7_glyph (
    input  logic [3:0] code,
    output logic [6:0] seg
);
    import seg7_pkg::*;

    always_comb begin
        seg = glyph(code);
    end

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed seven-segment driver: digit register file, scan counters,
// blink/leading-zero blanking and registered, polarity-adjusted pin outputs.
module seg7_scan_display #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 125,
    parameter int ACTIVE_LOW   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [2:0]            wr_addr,
    input  logic [3:0]            wr_code,
    input  logic [NUM_DIGITS-1:0] blink_en,
    input  logic                  lz_en,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  frame
);
    import seg7_pkg::*;

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);
    localparam logic [FW-1:0] FCNT_MAX  = FW'(BLINK_FRAMES - 1);

    logic [PW-1:0]         presc_reg, presc_next;
    logic [IW-1:0]         idx_reg, idx_next;
    logic [FW-1:0]         fcnt_reg, fcnt_next;
    logic                  phase_reg, phase_next;
    logic [3:0]            digit_reg [NUM_DIGITS];
    logic [6:0]            seg_reg, seg_next;
    logic [NUM_DIGITS-1:0] an_reg, an_next;
    logic                  frame_reg, frame_next;

    logic                  scan_wrap;
    logic                  frame_wrap;
    logic [3:0]            code_sel;
    logic [6:0]            glyph_seg;
    logic                  blank;
    logic [NUM_DIGITS:1]   zero_chain;
    logic [NUM_DIGITS-1:0] lz_mask;

    // Digit i is a leading zero when it and every digit above it hold code 0.
    assign zero_chain[NUM_DIGITS] = 1'b1;
    assign lz_mask[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < NUM_DIGITS; gi++) begin : g_lz
            assign zero_chain[gi] = zero_chain[gi+1] && (digit_reg[gi] == 4'h0);
            assign lz_mask[gi]    = lz_en && zero_chain[gi];
        end
    endgenerate

    always_comb begin
        scan_wrap  = (presc_reg == PRESC_MAX);
        frame_wrap = scan_wrap && (idx_reg == IDX_MAX);

        presc_next = scan_wrap ? '0 : presc_reg + 1'b1;
        idx_next   = idx_reg;
        if (scan_wrap) begin
            idx_next = (idx_reg == IDX_MAX) ? '0 : idx_reg + 1'b1;
        end

        fcnt_next  = fcnt_reg;
        phase_next = phase_reg;
        if (frame_wrap) begin
            if (fcnt_reg == FCNT_MAX) begin
                fcnt_next  = '0;
                phase_next = ~phase_reg;
            end else begin
                fcnt_next  = fcnt_reg + 1'b1;
            end
        end
    end

    // Outputs are computed from the upcoming scan state so the registered
    // pins line up with the prescaler/index they describe.
    assign code_sel = digit_reg[idx_next];

    seg7_glyph u_glyph (
        .code (code_sel),
        .seg  (glyph_seg)
    );

    always_comb begin
        blank      = (phase_next && blink_en[idx_next]) || lz_mask[idx_next];
        seg_next   = blank ? SEG_BLANK : glyph_seg;
        an_next    = '0;
        if (presc_next != '0) begin
            an_next[idx_next] = 1'b1;
        end
        frame_next = frame_wrap;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_reg <= '0;
            idx_reg   <= '0;
            fcnt_reg  <= '0;
            phase_reg <= 1'b0;
            seg_reg   <= SEG_BLANK;
            an_reg    <= '0;
            frame_reg <= 1'b0;
        end else begin
            presc_reg <= presc_next;
            idx_reg   <= idx_next;
            fcnt_reg  <= fcnt_next;
            phase_reg <= phase_next;
            seg_reg   <= seg_next;
            an_reg    <= an_next;
            frame_reg <= frame_next;
        end
    end

    // Addresses at or beyond NUM_DIGITS match no register and are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_reg[i] <= 4'h0;
            end
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (wr_en && (wr_addr == 3'(i))) begin
                    digit_reg[i] <= wr_code;
                end
            end
        end
    end

    assign seg   = (ACTIVE_LOW != 0) ? ~seg_reg : seg_reg;
    assign an    = (ACTIVE_LOW != 0) ? ~an_reg  : an_reg;
    assign frame = frame_reg;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display with SCAN_DIV=4, BLINK_FRAMES=2:
// one frame is 16 cycles, digit d of frame f is shown from cycle f*16+d*4+1.
module tb_seg7_scan_display;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = 3'd0;
    logic [3:0] wr_code = 4'd0;
    logic [3:0] blink_en = 4'd0;
    logic       lz_en = 1'b0;
    logic [6:0] seg, seg_al;
    logic [3:0] an, an_al;
    logic       frame, frame_al;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    seg7_scan_display #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLINK_FRAMES(2), .ACTIVE_LOW(0)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_code(wr_code),
        .blink_en(blink_en), .lz_en(lz_en), .seg(seg), .an(an), .frame(frame)
    );

    seg7_scan_display #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLINK_FRAMES(2), .ACTIVE_LOW(1)) dut_al (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_code(wr_code),
        .blink_en(blink_en), .lz_en(lz_en), .seg(seg_al), .an(an_al), .frame(frame_al)
    );

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic goto(input int target);
        n_checks++;
        assert (target >= cyc) else begin
            n_fail++;
            $error("FAIL goto: observed cycle %0d expected at most %0d", cyc, target);
        end
        while (cyc < target) tick();
    endtask

    task automatic write(input logic [2:0] addr, input logic [3:0] code);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_code = code;
        tick();
        wr_en   = 1'b0;
        $display("cycle %0d: write addr %0d code %h", cyc, addr, code);
    endtask

    task automatic check_an(input string tag, input logic [3:0] a);
        n_checks++;
        assert (an === a) else begin
            n_fail++;
            $error("FAIL %s an: observed %b expected %b", tag, an, a);
        end
        n_checks++;
        assert (an_al === ~a) else begin
            n_fail++;
            $error("FAIL %s an_al: observed %b expected %b", tag, an_al, ~a);
        end
    endtask

    task automatic check(input string tag, input logic [6:0] s, input logic [3:0] a);
        n_checks++;
        assert (seg === s) else begin
            n_fail++;
            $error("FAIL %s seg: observed %b expected %b", tag, seg, s);
        end
        n_checks++;
        assert (seg_al === ~s) else begin
            n_fail++;
            $error("FAIL %s seg_al: observed %b expected %b", tag, seg_al, ~s);
        end
        check_an(tag, a);
        $display("cycle %0d: %s seg=%b an=%b", cyc, tag, seg, an);
    endtask

    task automatic check_frame(input string tag, input logic f);
        n_checks++;
        assert (frame === f && frame_al === f) else begin
            n_fail++;
            $error("FAIL %s frame: observed %b/%b expected %b", tag, frame, frame_al, f);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cyc   = 0;

        check("reset", 7'b0000000, 4'b0000);
        check_frame("reset", 1'b0);

        // Scan walk with all registers at 0.
        goto(1);  check("d0_p1", 7'b1111110, 4'b0001);
        goto(2);  check("d0_p2", 7'b1111110, 4'b0001);
        goto(3);  check("d0_p3", 7'b1111110, 4'b0001);
        goto(4);  check_an("dead_idx1", 4'b0000);
        goto(5);  check_an("idx1", 4'b0010);
        goto(9);  check_an("idx2", 4'b0100);
        goto(13); check_an("idx3", 4'b1000);
        goto(15); check_frame("pre_wrap", 1'b0);
        goto(16); check_frame("wrap", 1'b1); check_an("wrap_dead", 4'b0000);
        goto(17); check_frame("post_wrap", 1'b0); check("wrap_idx0", 7'b1111110, 4'b0001);

        // Digit 1 is written on the same edge that moves the scan onto it.
        write(3'd0, 4'h1);
        write(3'd2, 4'h3);
        write(3'd1, 4'h2);
        write(3'd3, 4'hF);
        check("wr_on_advance", 7'b1101101, 4'b0010);

        goto(32); check_frame("wrap2", 1'b1);
        goto(33); check("d0_1", 7'b0110000, 4'b0001);
        goto(37); check("d1_2", 7'b1101101, 4'b0010);
        goto(41); check("d2_3", 7'b1111001, 4'b0100);
        goto(45); check("d3_F", 7'b1110111, 4'b1000);

        // Leading-zero blanking with {0,0,4,0}.
        lz_en = 1'b1;
        write(3'd3, 4'h0);
        write(3'd2, 4'h0);
        write(3'd1, 4'h4);
        write(3'd0, 4'h0);
        goto(65); check("lz_d0", 7'b1111110, 4'b0001);
        goto(69); check("lz_d1", 7'b0110011, 4'b0010);
        goto(73); check("lz_d2", 7'b0000000, 4'b0100);
        goto(77); check("lz_d3", 7'b0000000, 4'b1000);

        // Blank code on the top digit is nonzero and stops zero blanking.
        write(3'd3, 4'hC);
        goto(89); check("lz_stop_d2", 7'b1111110, 4'b0100);
        goto(93); check("code_blank_d3", 7'b0000000, 4'b1000);

        // Out-of-range address is ignored.
        write(3'd5, 4'h8);
        goto(97);  check("addr5_d0", 7'b1111110, 4'b0001);
        goto(101); check("addr5_d1", 7'b0110011, 4'b0010);
        goto(105); check("addr5_d2", 7'b1111110, 4'b0100);

        // Blink on digit 1: phase is 1 in frames 6,7,10 and 0 in frames 8,9.
        lz_en    = 1'b0;
        blink_en = 4'b0010;
        goto(113); check("blink_d0_f7", 7'b1111110, 4'b0001);
        goto(117); check("blink_d1_f7", 7'b0000000, 4'b0010);
        goto(133); check("blink_d1_f8", 7'b0110011, 4'b0010);
        goto(149); check("blink_d1_f9", 7'b0110011, 4'b0010);
        goto(165); check("blink_d1_f10", 7'b0000000, 4'b0010);

        // Asynchronous reset in the middle of a slot.
        goto(170);
        #1 reset = 1'b1;
        #1 check("async_reset", 7'b0000000, 4'b0000);
        check_frame("async_reset", 1'b0);
        @(negedge clk);
        reset    = 1'b0;
        blink_en = 4'b0000;
        cyc      = 0;
        goto(1);  check("post_reset_d0", 7'b1111110, 4'b0001);
        goto(5);  check("post_reset_d1", 7'b1111110, 4'b0010);
        goto(13); check("post_reset_d3", 7'b1111110, 4'b1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
